// File: rtl/word_serializer.sv
// Parallel-to-serial word shifter, LSB first, with frame start/last/busy strobes.
// Define WORD_SERIALIZER_GAP_EN to force an idle cycle between consecutive frames.
module word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sfrm,
  output logic             slast,
  output logic             sbusy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_reg, shift_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sout_nx, sfrm_nx, slast_nx, sbusy_nx;
  logic             last_bit, accept;

  // cnt is the index of the bit currently on sout
  assign last_bit = (state == SHIFT) && (cnt == LAST);

`ifdef WORD_SERIALIZER_GAP_EN
  assign din_ready = !r && (state == IDLE);
`else
  assign din_ready = !r && ((state == IDLE) || last_bit);
`endif

  assign accept = din_valid && din_ready;

  always_ff @(posedge t_clock) begin
    if (r) state <= IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit 0 goes straight to the output register on acceptance; the shift
  // register then holds only the bits still to come.
  always_comb begin
    shift_nx = shift_reg;
    cnt_nx   = cnt;
    sout_nx  = 1'b0;
    sfrm_nx  = 1'b0;
    slast_nx = 1'b0;
    sbusy_nx = 1'b0;
    if (accept) begin
      shift_nx = din >> 1;
      cnt_nx   = '0;
      sout_nx  = din[0];
      sfrm_nx  = 1'b1;
      sbusy_nx = 1'b1;
    end else if ((state == SHIFT) && !last_bit) begin
      shift_nx = shift_reg >> 1;
      cnt_nx   = cnt + 1'b1;
      sout_nx  = shift_reg[0];
      slast_nx = ((cnt + 1'b1) == LAST);
      sbusy_nx = 1'b1;
    end
  end

  always_ff @(posedge t_clock) begin
    if (r) begin
      shift_reg <= '0;
      cnt       <= '0;
      sout      <= 1'b0;
      sfrm      <= 1'b0;
      slast     <= 1'b0;
      sbusy     <= 1'b0;
    end else begin
      shift_reg <= shift_nx;
      cnt       <= cnt_nx;
      sout      <= sout_nx;
      sfrm      <= sfrm_nx;
      slast     <= slast_nx;
      sbusy     <= sbusy_nx;
    end
  end
endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits; legal range 2..32.
REQ-002 SHALL have port t_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-005 SHALL have port din_valid, input, 1 bit: din holds a word to be loaded.
REQ-006 SHALL have port din_ready, output, 1 bit: the serializer accepts din on this edge.
REQ-007 SHALL have port sout, output, 1 bit: serial data bit, LSB first; it drives the two's-complement stage's serial input.
REQ-008 SHALL have port sfrm, output, 1 bit: frame start, high while bit 0 is on sout; it drives the two's-complement stage's per-word reset.
REQ-009 SHALL have port slast, output, 1 bit: high while bit WIDTH-1 is on sout.
REQ-010 SHALL have port sbusy, output, 1 bit: high while any frame bit is on sout.

Function
REQ-011 SHALL implement an FSM with two states: IDLE and SHIFT.
REQ-012 SHALL define a word as accepted when din_valid and din_ready are both high at a rising edge.
REQ-013 SHALL load din into a WIDTH-bit shift register on acceptance, clear the bit counter and enter SHIFT.
REQ-014 SHALL register sout, sfrm, slast and sbusy, with latency exactly one cycle from the acceptance edge to bit 0 on sout.
REQ-015 SHALL, in SHIFT, present shift_reg[0] on sout, shift right by one and increment the counter at each edge.
REQ-016 SHALL make the counter ceil(log2(WIDTH)) bits wide, counting 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-017 SHALL keep sfrm high only in the bit-0 cycle and slast high only in the bit-(WIDTH-1) cycle.
REQ-018 SHALL keep sbusy high for exactly WIDTH consecutive cycles per frame.
REQ-019 SHALL drive din_ready combinationally: high in IDLE, low in SHIFT except the last-bit cycle (see REQ-025), and low whenever r is high.
REQ-020 SHALL, in IDLE with din_valid low, hold sout=0, sfrm=0, slast=0 and sbusy=0.
REQ-021 SHALL ignore din_valid and din while in SHIFT and not ready; the held word is accepted later, not lost.
REQ-022 SHALL return to IDLE after the last bit when no new word is accepted.

Reset
REQ-023 SHALL, with r high at an edge, force state IDLE, shift register 0, counter 0, and sout, sfrm, slast and sbusy to 0.
REQ-024 SHALL abort a frame when r is asserted mid-frame: no remaining bits are emitted, and the first acceptance is possible one edge after r deasserts.

Configuration
REQ-025 SHALL, without the macro WORD_SERIALIZER_GAP_EN defined:
- raise din_ready during the last-bit cycle;
- on acceptance there, present the new bit 0 with sfrm on the very next cycle, so frames run back-to-back with no bubble.
REQ-026 SHALL, with WORD_SERIALIZER_GAP_EN defined:
- hold din_ready low in the last-bit cycle;
- always pass through IDLE, guaranteeing at least one cycle with sbusy=0 and sout=0 between frames, so the downstream stage sees a frame boundary.

Verification (WIDTH=8)
REQ-027 SHALL cover: reset, then din=8'hB4 valid for one cycle -> sout over cycles 1..8 = 0,0,1,0,1,1,0,1; sfrm only in cycle 1; slast only in cycle 8; sbusy high in cycles 1..8.
REQ-028 SHALL cover: no macro, words 8'h01 then 8'h80 with valid held -> 16 contiguous bit cycles; sfrm in cycles 1 and 9; sout=1 in cycles 1 and 16 only.
REQ-029 SHALL cover: WORD_SERIALIZER_GAP_EN defined, same stimulus -> cycle 9 has sbusy=0 and sout=0; second sfrm in cycle 10.
REQ-030 SHALL cover: din_valid high with 8'hFF asserted in cycle 3 of a frame -> not accepted mid-frame; accepted at the first ready edge; emitted intact as eight 1s.
REQ-031 SHALL cover: r pulsed for one cycle after 3 bits of 8'hAA -> next cycle all outputs 0; no further bits; din_ready=1 from the cycle after r deasserts.
REQ-032 SHALL cover: idle for 10 cycles with din_valid=0 -> sout, sfrm, slast and sbusy remain 0 and din_ready remains 1.
